// File: rtl/rca_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : rca_shift_add_mult (with helper rca_Nbit)
// Description : Sequential unsigned N x N multiplier. One shift-and-add step
//               per clock around a single shared N-bit ripple-carry adder.
//               Start/busy/done handshake; 2N-bit registered product.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// rca_Nbit : plain N-bit ripple-carry adder built from full-adder cells.
// ----------------------------------------------------------------------------
module rca_Nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  // w_c[i] is the carry into bit i; w_c[N] is the final carry-out.
  logic [N:0] w_c;

  assign w_c[0] = i_cin;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign o_cout = w_c[N];

endmodule

// ----------------------------------------------------------------------------
// rca_shift_add_mult : shift-and-add controller around one rca_Nbit.
// ----------------------------------------------------------------------------
module rca_shift_add_mult #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  // Counter must hold the value N itself, hence N+1 codes.
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_m;        // multiplicand
  logic [N-1:0]     r_a;        // accumulator (upper half of partial product)
  logic [N-1:0]     r_q;        // multiplier, shifted out LSB-first
  logic [CW-1:0]    r_count;    // remaining add/shift steps
  logic [2*N-1:0]   r_product;
  logic             r_busy;
  logic             r_done;

  logic [N-1:0]     w_addend;
  logic [N-1:0]     w_sum;
  logic             w_cout;
  logic [N-1:0]     w_a_next;
  logic [N-1:0]     w_q_next;

  // Add the multiplicand only when the current multiplier bit is set.
  assign w_addend = r_q[0] ? r_m : '0;

  rca_Nbit #(.N(N)) u_rca (
    .i_a    (r_a),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Right shift of {C, S, Q}: the carry-out becomes the new accumulator MSB,
  // so nothing is lost even when every step carries.
  assign w_a_next = {w_cout, w_sum[N-1:1]};
  assign w_q_next = {w_sum[0], r_q[N-1:1]};

  // Controller and datapath registers: load on start, step in RUN, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= a;
            r_q     <= b;
            r_a     <= '0;
            r_count <= CW'(N);
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end

        S_RUN: begin
          r_a     <= w_a_next;
          r_q     <= w_q_next;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_product <= {w_a_next, w_q_next};
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end
        end

        S_DONE: begin
          // A start seen here is deliberately dropped; host re-issues in IDLE.
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_rca_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_shift_add_mult
// Description : Self-checking bench for rca_shift_add_mult (N=8 and N=16).
//               Expected products come from plain a*b arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, busy16, done16;
  logic [15:0] p8;
  logic [31:0] p16;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] last8 = '0;

  always #5 clk = ~clk;

  rca_shift_add_mult #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(p8)
  );

  rca_shift_add_mult #(.N(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(p16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete 8-bit operation with cycle-exact handshake checks.
  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] exp;
    exp    = 16'(a) * 16'(b);
    start8 = 1'b1; a8 = a; b8 = b;
    tick;
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      chk("busy8_run", {63'd0, busy8}, 64'd1);
      chk("done8_run", {63'd0, done8}, 64'd0);
      chk("hold8_run", {48'd0, p8}, {48'd0, last8});
      tick;
    end
    chk("done8_pulse", {63'd0, done8}, 64'd1);
    chk("busy8_done", {63'd0, busy8}, 64'd0);
    chk("prod8",      {48'd0, p8}, {48'd0, exp});
    last8 = exp;
    tick;
    chk("done8_idle", {63'd0, done8}, 64'd0);
    chk("busy8_idle", {63'd0, busy8}, 64'd0);
    chk("hold8_idle", {48'd0, p8}, {48'd0, exp});
  endtask

  // One 16-bit operation; latency measured against a bounded wait.
  task automatic run16(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] exp;
    int          lat;
    exp     = 32'(a) * 32'(b);
    start16 = 1'b1; a16 = a; b16 = b;
    tick;
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 40) begin
      tick;
      lat++;
    end
    chk("lat16",  64'(lat), 64'd16);
    chk("prod16", {32'd0, p16}, {32'd0, exp});
    tick;
  endtask

  initial begin
    rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    tick; tick;
    chk("rst_busy8", {63'd0, busy8}, 64'd0);
    chk("rst_done8", {63'd0, done8}, 64'd0);
    chk("rst_prod8", {48'd0, p8}, 64'd0);
    chk("rst_prod16", {32'd0, p16}, 64'd0);
    rst = 1'b0;
    tick;

    // Basic, all-carry, and zero-operand back-to-back operations.
    run8(8'd13, 8'd11);
    chk("prod8_143", {48'd0, p8}, 64'h008F);
    run8(8'd255, 8'd255);
    chk("prod8_fe01", {48'd0, p8}, 64'hFE01);
    run8(8'd0, 8'd200);
    run8(8'd200, 8'd0);

    // start held high throughout: second op only accepted from IDLE.
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd9;
    tick;
    for (int i = 0; i < 8; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      chk("hs_busy", {63'd0, busy8}, 64'd1);
      tick;
    end
    chk("hs_done", {63'd0, done8}, 64'd1);
    chk("hs_prod63", {48'd0, p8}, 64'd63);
    a8 = 8'd5; b8 = 8'd6;
    tick;
    chk("hs_idle_busy", {63'd0, busy8}, 64'd0);
    chk("hs_idle_done", {63'd0, done8}, 64'd0);
    tick;
    chk("hs_accept", {63'd0, busy8}, 64'd1);
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) tick;
    chk("hs_done2", {63'd0, done8}, 64'd1);
    chk("hs_prod30", {48'd0, p8}, 64'd30);
    last8 = 16'd30;
    tick;

    // Reset in the middle of an operation abandons it completely.
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd3;
    tick;
    start8 = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mr_busy", {63'd0, busy8}, 64'd0);
    chk("mr_done", {63'd0, done8}, 64'd0);
    chk("mr_prod", {48'd0, p8}, 64'd0);
    for (int i = 0; i < 12; i++) begin
      chk("mr_no_done", {63'd0, done8}, 64'd0);
      tick;
    end
    last8 = '0;
    run8(8'd100, 8'd3);
    chk("prod8_300", {48'd0, p8}, 64'h012C);

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 10; i++) run8(8'($urandom), 8'($urandom));

    // Wider instance: parameterisation and counter width.
    run16(16'hFFFF, 16'h0001);
    chk("prod16_ffff", {32'd0, p16}, 64'h0000FFFF);
    run16(16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 4; i++) run16(16'($urandom), 16'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
